req_ack_32bit_sender: RTL and testbench

- Downlink counterpart of the 32-bit request/acknowledge receiver: accepts 64-bit AXI-Stream frames from the host-side FIFO and delivers each to PAICORE as two 32-bit words (high word first) over a four-phase req/ack handshake.
- Sits between the transmit FIFO and the chip pins.
- Reports per-beat handshakes, busy status and end-of-packet completion to the control/status logic.

---
 rtl/req_ack_32bit_sender_if.sv | 33 +++
 rtl/req_ack_32bit_sender.sv | 176 +++++++++++++++++
 tb/tb_req_ack_32bit_sender.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/req_ack_32bit_sender_if.sv
// rtl/req_ack_32bit_sender_if.sv - frame stream and PAICORE req/ack pin bundle
interface req_ack_32bit_sender_if;
  logic        s_axis_tready;
  logic [63:0] s_axis_tdata;
  logic        s_axis_tlast;
  logic        s_axis_tvalid;
  logic        s_axis_hsked;
  logic [31:0] dout;
  logic        request;
  logic        acknowledge;

  modport slave (
    output s_axis_tready,
    output s_axis_hsked,
    output dout,
    output request,
    input  s_axis_tdata,
    input  s_axis_tlast,
    input  s_axis_tvalid,
    input  acknowledge
  );

  modport master (
    input  s_axis_tready,
    input  s_axis_hsked,
    input  dout,
    input  request,
    output s_axis_tdata,
    output s_axis_tlast,
    output s_axis_tvalid,
    output acknowledge
  );
endinterface

// File: rtl/req_ack_32bit_sender.sv
// rtl/req_ack_32bit_sender.sv - 64-bit frame to two 32-bit words over four-phase req/ack
// Optional acknowledge-wait timeout: PAICORE_SEND_TIMEOUT_EN.
module req_ack_32bit_sender #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned SETUP_CYC   = 1
`ifdef PAICORE_SEND_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYC = 65535
`endif
) (
  input  logic                         s_axis_aclk,
  input  logic                         s_axis_areset,
  req_ack_32bit_sender_if.slave        bus,
  output logic                         o_tx_busy,
  output logic                         o_tx_done,
  output logic [31:0]                  o_frame_cnt
`ifdef PAICORE_SEND_TIMEOUT_EN
  ,
  output logic                         o_timeout
`endif
);

  typedef enum logic [2:0] {
    IDLE,
    SETUP_H,
    REQ_H,
    REL_H,
    SETUP_L,
    REQ_L,
    REL_L
  } state_t;

  localparam logic [3:0] SETUP_LAST = 4'(SETUP_CYC - 1);

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_sync_q;
  logic                   ack_s;
  logic [3:0]             setup_cnt_q, setup_cnt_d;
  logic [31:0]            dout_q, dout_d;
  logic [31:0]            lo_q, lo_d;
  logic                   last_q, last_d;
  logic                   request_q, request_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic [31:0]            frame_cnt_q, frame_cnt_d;
  logic                   tready;
`ifdef PAICORE_SEND_TIMEOUT_EN
  localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYC - 1);
  logic [31:0]            wait_cnt_q, wait_cnt_d;
  logic                   timeout_q, timeout_d;
  logic                   waiting;
`endif

  assign ack_s  = ack_sync_q[SYNC_STAGES-1];
  assign tready = (state_q == IDLE) && !s_axis_areset;

  assign bus.s_axis_tready = tready;
  assign bus.s_axis_hsked  = tready && bus.s_axis_tvalid;
  assign bus.dout          = dout_q;
  assign bus.request       = request_q;
  assign o_tx_busy         = busy_q;
  assign o_tx_done         = done_q;
  assign o_frame_cnt       = frame_cnt_q;
`ifdef PAICORE_SEND_TIMEOUT_EN
  assign o_timeout         = timeout_q;
`endif

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], bus.acknowledge};
    end
  end

  always_comb begin
    state_d     = state_q;
    setup_cnt_d = setup_cnt_q;
    dout_d      = dout_q;
    lo_d        = lo_q;
    last_d      = last_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (bus.s_axis_tvalid) begin
          dout_d      = bus.s_axis_tdata[63:32];
          lo_d        = bus.s_axis_tdata[31:0];
          last_d      = bus.s_axis_tlast;
          busy_d      = 1'b1;
          setup_cnt_d = '0;
          state_d     = SETUP_H;
        end
      end
      SETUP_H, SETUP_L: begin
        // A stale acknowledge still high means the far side has not released; hold off.
        if (ack_s) begin
          setup_cnt_d = '0;
        end else if (setup_cnt_q == SETUP_LAST) begin
          state_d = (state_q == SETUP_H) ? REQ_H : REQ_L;
        end else begin
          setup_cnt_d = setup_cnt_q + 4'd1;
        end
      end
      REQ_H: if (ack_s) state_d = REL_H;
      REQ_L: if (ack_s) state_d = REL_L;
      REL_H: begin
        if (!ack_s) begin
          dout_d      = lo_q;
          setup_cnt_d = '0;
          state_d     = SETUP_L;
        end
      end
      REL_L: begin
        if (!ack_s) begin
          frame_cnt_d = frame_cnt_q + 32'd1;
          busy_d      = 1'b0;
          done_d      = last_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

`ifdef PAICORE_SEND_TIMEOUT_EN
    timeout_d = timeout_q;
    waiting   = (state_q == REQ_H) || (state_q == REQ_L) ||
                (state_q == REL_H) || (state_q == REL_L);
    if (waiting && (wait_cnt_q == TIMEOUT_LAST)) begin
      state_d     = IDLE;
      busy_d      = 1'b0;
      done_d      = 1'b0;
      frame_cnt_d = frame_cnt_q;
      timeout_d   = 1'b1;
    end
    wait_cnt_d = (state_d != state_q || !waiting) ? 32'd0 : wait_cnt_q + 32'd1;
`endif

    request_d = (state_d == REQ_H) || (state_d == REQ_L);
  end

  always_ff @(posedge s_axis_aclk) begin
    if (s_axis_areset) begin
      state_q     <= IDLE;
      setup_cnt_q <= '0;
      dout_q      <= '0;
      lo_q        <= '0;
      last_q      <= 1'b0;
      request_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      frame_cnt_q <= '0;
`ifdef PAICORE_SEND_TIMEOUT_EN
      wait_cnt_q  <= '0;
      timeout_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      setup_cnt_q <= setup_cnt_d;
      dout_q      <= dout_d;
      lo_q        <= lo_d;
      last_q      <= last_d;
      request_q   <= request_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      frame_cnt_q <= frame_cnt_d;
`ifdef PAICORE_SEND_TIMEOUT_EN
      wait_cnt_q  <= wait_cnt_d;
      timeout_q   <= timeout_d;
`endif
    end
  end

endmodule

// File: tb/tb_req_ack_32bit_sender.sv
// tb/tb_req_ack_32bit_sender.sv - scoreboard bench for req_ack_32bit_sender
module tb_req_ack_32bit_sender;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  req_ack_32bit_sender_if bus();
  logic        busy;
  logic        done;
  logic [31:0] fcnt;
`ifdef PAICORE_SEND_TIMEOUT_EN
  logic        tmo;
`endif

  req_ack_32bit_sender #(
    .SYNC_STAGES(2),
    .SETUP_CYC(1)
`ifdef PAICORE_SEND_TIMEOUT_EN
    ,
    .TIMEOUT_CYC(100)
`endif
  ) dut (
    .s_axis_aclk(clk),
    .s_axis_areset(rst),
    .bus(bus.slave),
    .o_tx_busy(busy),
    .o_tx_done(done),
    .o_frame_cnt(fcnt)
`ifdef PAICORE_SEND_TIMEOUT_EN
    ,
    .o_timeout(tmo)
`endif
  );

  int checks = 0;
  int passes = 0;
  logic [31:0] exp_words[$];
  logic [31:0] exp_done[$];
  int model_cnt = 0;
  int req_rises = 0;
  int done_seen = 0;

  bit ack_stuck = 1'b0;
  bit silent    = 1'b0;
  bit rand_mode = 1'b0;
  int ack_delay = 3;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic fail_now(input string name);
    checks++;
    $display("FAIL %s: got bound expired expected event", name);
  endtask

  // Acknowledge responder: follows request after ack_delay cycles, off the sampling edge.
  initial begin
    int cnt = 0;
    bus.acknowledge = 1'b0;
    forever begin
      @(negedge clk);
      #2;
      if (ack_stuck) begin
        bus.acknowledge = 1'b1;
        cnt = 0;
      end else if (silent) begin
        bus.acknowledge = 1'b0;
      end else if (bus.request !== bus.acknowledge) begin
        if (cnt >= ack_delay) begin
          bus.acknowledge = bus.request;
          cnt = 0;
          if (rand_mode) ack_delay = $urandom_range(0, 20);
        end else begin
          cnt++;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    logic        prev_req  = 1'b0;
    logic [31:0] prev_dout = '0;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      if (bus.request && !prev_req) begin
        req_rises++;
        check("req_rise_ack_low", 64'(bus.acknowledge), 64'd0);
        if (exp_words.size() == 0) begin
          checks++;
          $display("FAIL unexpected_word: got 0x%0h expected none", bus.dout);
        end else begin
          w = exp_words.pop_front();
          check("dout_word", 64'(bus.dout), 64'(w));
        end
      end
      if (bus.request && prev_req) check("dout_stable", 64'(bus.dout), 64'(prev_dout));
      if (done) begin
        done_seen++;
        if (exp_done.size() == 0) begin
          checks++;
          $display("FAIL unexpected_done: got frame_cnt %0d expected no pulse", fcnt);
        end else begin
          w = exp_done.pop_front();
          check("done_frame_cnt", 64'(fcnt), 64'(w));
        end
      end
      prev_req  = bus.request;
      prev_dout = bus.dout;
    end
  end

  task automatic send(input logic [63:0] d, input logic l, input bit keep);
    int n = 0;
    bus.s_axis_tdata  = d;
    bus.s_axis_tlast  = l;
    bus.s_axis_tvalid = 1'b1;
    #1;
    while (!bus.s_axis_tready && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!bus.s_axis_tready) begin
      fail_now("accept_wait");
      bus.s_axis_tvalid = 1'b0;
      return;
    end
    check("hsked", 64'(bus.s_axis_hsked), 64'd1);
    exp_words.push_back(d[63:32]);
    exp_words.push_back(d[31:0]);
    model_cnt++;
    if (l) exp_done.push_back(32'(model_cnt));
    @(negedge clk);
    if (!keep) bus.s_axis_tvalid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || !bus.s_axis_tready || exp_words.size() != 0) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 5000) fail_now("idle_wait");
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int base_r;
    int base_d;
    int n;
    bus.s_axis_tdata  = 64'h0;
    bus.s_axis_tlast  = 1'b0;
    bus.s_axis_tvalid = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_tready", 64'(bus.s_axis_tready), 64'd0);
    check("rst_hsked", 64'(bus.s_axis_hsked), 64'd0);
    check("rst_request", 64'(bus.request), 64'd0);
    check("rst_dout", 64'(bus.dout), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_frame_cnt", 64'(fcnt), 64'd0);
    bus.s_axis_tvalid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_tready", 64'(bus.s_axis_tready), 64'd1);
    @(negedge clk);

    // Single frame, ack delay 3.
    base_r = req_rises;
    base_d = done_seen;
    send(64'h11223344_55667788, 1'b1, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    check("single_req_pulses", 64'(req_rises - base_r), 64'd2);
    check("single_done_pulses", 64'(done_seen - base_d), 64'd1);
    check("single_frame_cnt", 64'(fcnt), 64'd1);
    check("single_busy", 64'(busy), 64'd0);

    // Three frames with tvalid held, tlast on the third.
    base_d = done_seen;
    send(64'hA0A0A0A0_B0B0B0B0, 1'b0, 1'b1);
    check("held_tready_low", 64'(bus.s_axis_tready), 64'd0);
    check("held_busy", 64'(busy), 64'd1);
    send(64'hA1A1A1A1_B1B1B1B1, 1'b0, 1'b1);
    check("held_tready_low2", 64'(bus.s_axis_tready), 64'd0);
    send(64'hA2A2A2A2_B2B2B2B2, 1'b1, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    check("held_done_pulses", 64'(done_seen - base_d), 64'd1);
    check("held_frame_cnt", 64'(fcnt), 64'd4);

    // Random ack delays over 1000 frames.
    rand_mode = 1'b1;
    ack_delay = $urandom_range(0, 20);
    for (int i = 0; i < 1000; i++) begin
      send({$urandom, $urandom}, (i == 999) ? 1'b1 : 1'b0, 1'b0);
    end
    wait_idle();
    rand_mode = 1'b0;
    ack_delay = 3;
    repeat (2) @(negedge clk);
    check("rand_frame_cnt", 64'(fcnt), 64'(model_cnt));

    // Acknowledge stuck high before the frame arrives.
    ack_stuck = 1'b1;
    repeat (6) @(negedge clk);
    base_r = req_rises;
    send(64'hDEADBEEF_CAFEF00D, 1'b0, 1'b0);
    repeat (20) @(negedge clk);
    check("stuck_request", 64'(bus.request), 64'd0);
    check("stuck_no_rise", 64'(req_rises - base_r), 64'd0);
    check("stuck_busy", 64'(busy), 64'd1);
    ack_stuck = 1'b0;
    wait_idle();
    repeat (2) @(negedge clk);
    check("stuck_frame_cnt", 64'(fcnt), 64'(model_cnt));

    // Reset during REQ_L of the second of two frames.
    send(64'h01020304_05060708, 1'b1, 1'b0);
    wait_idle();
    ack_delay = 10;
    base_r = req_rises;
    send(64'h0A0B0C0D_0E0F1011, 1'b0, 1'b0);
    n = 0;
    while (req_rises < base_r + 2 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) fail_now("reql_wait");
    rst = 1'b1;
    @(negedge clk);
    check("abort_request", 64'(bus.request), 64'd0);
    check("abort_dout", 64'(bus.dout), 64'd0);
    check("abort_frame_cnt", 64'(fcnt), 64'd0);
    check("abort_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    model_cnt = 0;
    ack_delay = 3;
    #1;
    check("abort_tready", 64'(bus.s_axis_tready), 64'd1);
    @(negedge clk);
    send(64'h76543210_FEDCBA98, 1'b1, 1'b0);
    wait_idle();
    repeat (2) @(negedge clk);
    check("after_abort_frame_cnt", 64'(fcnt), 64'd1);

`ifdef PAICORE_SEND_TIMEOUT_EN
    // Silent responder: acknowledge-wait limit of 100 cycles.
    silent = 1'b1;
    check("tmo_before", 64'(tmo), 64'd0);
    send(64'h13579BDF_2468ACE0, 1'b0, 1'b0);
    n = 0;
    while (!bus.request && n < 100) begin
      @(negedge clk);
      n++;
    end
    n = 0;
    while (bus.request && n < 500) begin
      n++;
      @(negedge clk);
    end
    check("tmo_req_cycles", 64'(n), 64'd100);
    check("tmo_flag", 64'(tmo), 64'd1);
    void'(exp_words.pop_back());
    model_cnt--;
    check("tmo_frame_cnt", 64'(fcnt), 64'(model_cnt));
    check("tmo_tready", 64'(bus.s_axis_tready), 64'd1);
    check("tmo_busy", 64'(busy), 64'd0);
    silent = 1'b0;
    repeat (5) @(negedge clk);
    check("tmo_sticky", 64'(tmo), 64'd1);
`endif

    check("words_drained", 64'(exp_words.size()), 64'd0);
    check("done_drained", 64'(exp_done.size()), 64'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
